// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler feeding uart_tx from the RX echo path and the keypad.
// Optional build macro TX_SCHED_CRLF_EN: each key byte is followed by CR/LF.
module uart_tx_sched #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       key_en,
  input  logic [3:0] key_value,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  localparam int FRAME_CYCLES = (CLK_FREQ / BAUD_RATE) * 11;
  localparam int CW           = $clog2(FRAME_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rx_pend, r_key_pend, r_last_key;
  logic [7:0]    r_rx_byte, r_key_byte;
`ifdef TX_SCHED_CRLF_EN
  logic [1:0]    r_seq;
`endif

  logic       w_idle, w_gnt_rx, w_gnt_key, w_drop_rx, w_drop_key;
  logic [7:0] w_key_ascii;
  logic [8:0] w_drop_sum;

  assign w_key_ascii = (key_value < 4'd10) ? (8'h30 + {4'h0, key_value})
                                           : (8'h37 + {4'h0, key_value});
  assign w_idle      = (r_state == S_IDLE);
  // Tie goes to whichever source was not served last.
  assign w_gnt_rx    = w_idle & r_rx_pend & (~r_key_pend | r_last_key);
  assign w_gnt_key   = w_idle & r_key_pend & ~w_gnt_rx;
  assign w_drop_rx   = rx_done & r_rx_pend & ~w_gnt_rx;
  assign w_drop_key  = key_en & r_key_pend & ~w_gnt_key;
  assign w_drop_sum  = {1'b0, drop_cnt} + {8'd0, w_drop_rx} + {8'd0, w_drop_key};

  // A slot being granted this cycle hands over its old byte and may take a new one.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rx_pend  <= 1'b0;
      r_key_pend <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_key_byte <= 8'h00;
      drop_cnt   <= 8'h00;
    end else begin
      if (rx_done && (!r_rx_pend || w_gnt_rx)) begin
        r_rx_pend <= 1'b1;
        r_rx_byte <= rx_data;
      end else if (w_gnt_rx) begin
        r_rx_pend <= 1'b0;
      end
      if (key_en && (!r_key_pend || w_gnt_key)) begin
        r_key_pend <= 1'b1;
        r_key_byte <= w_key_ascii;
      end else if (w_gnt_key) begin
        r_key_pend <= 1'b0;
      end
      drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      r_cnt      <= '0;
      r_last_key <= 1'b1;
`ifdef TX_SCHED_CRLF_EN
      r_seq      <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_rx || w_gnt_key) begin
            r_state    <= S_START;
            tx_start   <= 1'b1;
            busy       <= 1'b1;
            tx_data    <= w_gnt_rx ? r_rx_byte : r_key_byte;
            r_last_key <= w_gnt_key;
`ifdef TX_SCHED_CRLF_EN
            r_seq      <= w_gnt_key ? 2'd2 : 2'd0;
`endif
          end
        end
        S_START: begin
          tx_start <= 1'b0;
          r_cnt    <= CW'(FRAME_CYCLES - 1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
`ifdef TX_SCHED_CRLF_EN
            if (r_seq != 2'd0) begin
              r_state  <= S_START;
              tx_start <= 1'b1;
              tx_data  <= (r_seq == 2'd2) ? 8'h0D : 8'h0A;
              r_seq    <= r_seq - 2'd1;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
`else
            r_state <= S_IDLE;
            busy    <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: timestamped transaction model vs. monitor.
module tb_uart_tx_sched;
  localparam int F = 110;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n, rx_done, key_en;
  logic [7:0] rx_data;
  logic [3:0] key_value;
  logic       tx_start, busy;
  logic [7:0] tx_data, drop_cnt;

  uart_tx_sched #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .rx_done(rx_done), .rx_data(rx_data),
    .key_en(key_en), .key_value(key_value),
    .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int t; } exp_t;
  exp_t q[$];

  // model: pending slots, the first cycle a grant may happen, and the busy window
  bit         m_prx = 0, m_pky = 0, m_last_key = 1;
  logic [7:0] m_brx = 0, m_bky = 0;
  int         m_free = 0, m_blo = 0, m_bhi = 0, m_drop = 0, m_rst_cyc = -10;
  int         total = 0, bad = 0;
  logic [7:0] exp_txd = 8'h00;
  int         last_st_cyc = -1;
  logic [7:0] last_st_d = 8'h00;
  int         step_cyc = 0;

  function automatic logic [7:0] ascii(input logic [3:0] v);
    int iv;
    iv = v;
    return (iv < 10) ? 8'(48 + iv) : 8'(65 + iv - 10);
  endfunction

  task automatic step(input bit rx, input logic [7:0] rd, input bit ky,
                      input logic [3:0] kv, input bit rst_n);
    int n;
    exp_t e;
    bit grx, gky;
    @(negedge sys_clk);
    n = cyc;
    step_cyc = n;
    rx_done = rx; rx_data = rd; key_en = ky; key_value = kv; sys_rst_n = rst_n;
    if (!rst_n) begin
      while (q.size() > 0 && q[q.size()-1].t > n) q.delete(q.size()-1);
      m_prx = 0; m_pky = 0; m_last_key = 1; m_free = n + 1; m_drop = 0;
      if (m_bhi > n + 1) m_bhi = n + 1;
      m_rst_cyc = n;
    end else begin
      grx = 0; gky = 0;
      if (n >= m_free) begin
        grx = m_prx && (!m_pky || m_last_key);
        gky = m_pky && !grx;
      end
      if (grx || gky) begin
        e.t = n + 1; e.d = grx ? m_brx : m_bky; q.push_back(e);
        m_blo = n + 1; m_last_key = gky;
        if (grx) m_prx = 0; else m_pky = 0;
        m_free = n + F + 2;
`ifdef TX_SCHED_CRLF_EN
        if (gky) begin
          e.t = n + 1 + (F + 1);   e.d = 8'h0D; q.push_back(e);
          e.t = n + 1 + 2*(F + 1); e.d = 8'h0A; q.push_back(e);
          m_free = n + 1 + 3*(F + 1);
        end
`endif
        m_bhi = m_free;
      end
      if (rx) begin
        if (m_prx) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else begin m_prx = 1; m_brx = rd; end
      end
      if (ky) begin
        if (m_pky) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else begin m_pky = 1; m_bky = ascii(kv); end
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 8'h00, 0, 4'h0, 1);
  endtask

  // monitor: samples each cycle just after the edge, against model state of earlier cycles
  initial begin
    exp_t e;
    bit exp_busy;
    forever begin
      @(posedge sys_clk); #1;
      if (m_rst_cyc == cyc - 1) exp_txd = 8'h00;
      while (q.size() > 0 && q[0].t < cyc) begin
        total++; bad++;
        $display("FAIL missed_start: no tx_start at cycle %0d, required data %02h", q[0].t, q[0].d);
        void'(q.pop_front());
      end
      if (tx_start === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start: tx_start at cycle %0d data %02h, none required", cyc, tx_data);
        end else if (q[0].t != cyc) begin
          bad++;
          $display("FAIL early_start: tx_start at cycle %0d, required at %0d", cyc, q[0].t);
        end else begin
          e = q.pop_front();
          exp_txd = e.d;
          if (tx_data !== e.d) begin
            bad++;
            $display("FAIL start_data: cycle %0d got %02h required %02h", cyc, tx_data, e.d);
          end
        end
        last_st_cyc = cyc; last_st_d = tx_data;
      end
      exp_busy = (cyc >= m_blo) && (cyc < m_bhi);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy: cycle %0d got %b required %b", cyc, busy, exp_busy);
      end
      total++;
      if (tx_data !== exp_txd) begin
        bad++;
        $display("FAIL tx_data_hold: cycle %0d got %02h required %02h", cyc, tx_data, exp_txd);
      end
      total++;
      if (drop_cnt !== 8'(m_drop)) begin
        bad++;
        $display("FAIL drop_cnt: cycle %0d got %0d required %0d", cyc, drop_cnt, m_drop);
      end
    end
  end

  initial begin
    int c0;
    sys_rst_n = 1'b0; rx_done = 1'b0; key_en = 1'b0; rx_data = 8'h00; key_value = 4'h0;
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 4'h0, 0);
    idle(500);

    // key 0xB -> 'B' two cycles later
    step(0, 8'h00, 1, 4'hB, 1); c0 = step_cyc;
    idle(2);
    total++;
    if (last_st_cyc != c0 + 2 || last_st_d !== 8'h42) begin
      bad++;
      $display("FAIL key_first_start: cycle %0d data %02h, required cycle %0d data 42", last_st_cyc, last_st_d, c0 + 2);
    end
    idle(400);

    // simultaneous rx and key: RX first, key 112 cycles later
    step(1, 8'h55, 1, 4'h3, 1); c0 = step_cyc;
    idle(114);
    total++;
    if (last_st_cyc != c0 + 114 || last_st_d !== 8'h33) begin
      bad++;
      $display("FAIL tie_order: last start cycle %0d data %02h, required cycle %0d data 33", last_st_cyc, last_st_d, c0 + 114);
    end
    total++;
    if (drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL tie_no_drop: drop_cnt %0d required 0", drop_cnt);
    end
    idle(400);

    // three rx bytes against an already-pending slot
    step(1, 8'hAA, 0, 4'h0, 1);
    idle(5);
    step(1, 8'h01, 0, 4'h0, 1);
    step(1, 8'h02, 0, 4'h0, 1);
    step(1, 8'h03, 0, 4'h0, 1);
    idle(300);
    total++;
    if (drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL pending_drops: drop_cnt %0d required 2", drop_cnt);
    end

    // reset in the middle of a frame, with an rx byte waiting
    step(0, 8'h00, 1, 4'h5, 1); c0 = step_cyc;
    idle(9);
    step(1, 8'h77, 0, 4'h0, 1);
    idle(42);
    step(0, 8'h00, 0, 4'h0, 0);
    idle(400);
    total++;
    if (last_st_cyc != c0 + 2) begin
      bad++;
      $display("FAIL reset_abort: last start cycle %0d, required %0d", last_st_cyc, c0 + 2);
    end

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 59) == 0,
           4'($urandom), $urandom_range(0, 1999) != 0);
    idle(400);

    // flood the rx slot so the drop counter saturates
    for (int i = 0; i < 400; i++) step(1, 8'($urandom), i[0], 4'($urandom), 1);
    idle(400);
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL drop_saturate: drop_cnt %0d required 255", drop_cnt);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d starts still outstanding, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares the single `uart_tx` serializer between two byte sources: the UART receive echo path (`uart_rx` done/data) and the matrix-keypad decoder (`Value_en`/`KEY_Value`). It buffers one pending byte per source and arbitrates round-robin. Because `uart_tx` has no busy output, the scheduler paces frames with its own frame-time counter. It drives `tx_start`/`data` of `uart_tx` and sits beside `KeyValue` and `uart_rx` in the top level.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, UART baud rate; must match `uart_tx`
- `sys_clk`  in  1  system clock, all logic on rising edge
- `sys_rst_n`  in  1  reset, synchronous, active-low
- `rx_done`  in  1  one-cycle pulse, a received byte is on `rx_data`
- `rx_data`  in  8  received byte, valid while `rx_done`=1
- `key_en`  in  1  one-cycle pulse, a new key is on `key_value`
- `key_value`  in  4  keypad code 0..15, valid while `key_en`=1
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`
- `tx_data`  out  8  byte to `uart_tx`, held stable for the entire frame
- `busy`  out  1  high whenever state is not IDLE
- `drop_cnt`  out  8  saturating count of events lost to a full slot

## Operation
- Derived constant: FRAME_CYCLES = (CLK_FREQ/BAUD_RATE)*11, using integer division. This is 10 bit times plus one guard bit. Defaults give 434*11 = 4774.
- Two one-entry slots, each holding a pending flag and a byte:
  - RX slot captures `rx_data` unchanged.
  - KEY slot captures ASCII of `key_value`: 0..9 map to 0x30..0x39, 10..15 map to 0x41..0x46.
- Event arrives while its slot is pending and the slot is not being granted that same cycle: the event is dropped and `drop_cnt` increments, saturating at 255.
- Event arrives in the same cycle its slot is granted: the grant takes the old byte and the new byte is captured. Nothing is dropped.
- `rx_done` and `key_en` in the same cycle: both are captured independently.
- Arbitration happens in IDLE when at least one slot is pending:
  - Only one slot pending: grant it.
  - Both pending: grant the source not granted last.
  - `last_grant` resets to KEY, so RX wins the first tie.
- FSM states:
  - IDLE: leave on a grant to START.
  - START: `tx_start`=1 for this cycle. Load `tx_data`, clear the granted slot's pending flag, load the counter with FRAME_CYCLES-1. Go to WAIT.
  - WAIT: decrement the counter each cycle. When it reads 0, go to IDLE, or go to START of the next byte in a multi-byte sequence (see Configuration).
- Reset values: `tx_start`=0, `tx_data`=0x00, `busy`=0, `drop_cnt`=0, both slots empty, state IDLE, counter 0.
- Reset asserted mid-frame aborts the frame immediately and discards both slots. Any partly sent bit in `uart_tx` is its own reset's concern.

## Timing
- Event pulse in cycle N: the slot is pending from N+1.
- If IDLE with no other pending work: state is START and `tx_start`=1 in cycle N+2, with `tx_data` valid in the same cycle.
- `tx_start` at cycle T:
  - WAIT occupies T+1 .. T+FRAME_CYCLES.
  - IDLE at T+FRAME_CYCLES+1.
  - Next single-byte `tx_start` no earlier than T+FRAME_CYCLES+2.
- Within a multi-byte sequence, the next `tx_start` is at T+FRAME_CYCLES+1.
- `tx_data` changes only in a START cycle.
- `busy` is registered: it rises at the START cycle and falls at the first IDLE cycle.

## Configuration
- `TX_SCHED_CRLF_EN` defined:
  - A KEY grant sends three bytes back-to-back: ASCII char, 0x0D, 0x0A.
  - The sequence is atomic; an RX grant cannot interleave.
  - The KEY slot frees at the first START, so a new key may be captured during the CR/LF frames.
  - RX grants remain single-byte.
- `TX_SCHED_CRLF_EN` undefined: every grant is one byte, and no CR/LF logic is synthesized.

## Test plan
Use CLK_FREQ=1000, BAUD_RATE=100, giving FRAME_CYCLES=110.
- Reset held 3 cycles, then released with no events -> `tx_start`, `busy`, `drop_cnt` all 0 and `tx_data`=0x00 for 500 cycles.
- `key_en` with `key_value`=0xB at cycle 10 -> `tx_start` at cycle 12 with `tx_data`=0x42; `busy` falls at cycle 123.
- `rx_done`(0x55) and `key_en`(3) in the same cycle -> 0x55 sent first; 0x33 `tx_start` exactly 112 cycles later; `drop_cnt`=0.
- During a frame, three `rx_done` pulses (0x01, 0x02, 0x03) arrive while the slot is already pending -> first captured, `drop_cnt`=2, only 0x01 is transmitted after the current frame.
- With `TX_SCHED_CRLF_EN`, `key_en`(7) -> `tx_data` sequence 0x37, 0x0D, 0x0A, with `tx_start` spaced 111 cycles apart; an `rx_done` arriving mid-sequence is sent after 0x0A.
- `sys_rst_n` low for 1 cycle at T+50 of a frame -> next cycle IDLE, `busy`=0, slots empty, no further `tx_start`.
